// File: rtl/vga_rect_fill.sv
// Rectangle fill generator for the VGA adapter plot bus: clips to the active area, one write per clock.
// Defining VGA_RECT_OUTLINE_EN adds an 'outline' input that plots only the border pixels.
module vga_rect_fill #(
    parameter int unsigned XW   = 8,
    parameter int unsigned YW   = XW - 1,
    parameter int unsigned XRES = 160,
    parameter int unsigned YRES = 120
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] width,
    input  logic [YW-1:0] height,
    input  logic [2:0]    color,
`ifdef VGA_RECT_OUTLINE_EN
    input  logic          outline,
`endif
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] VGA_X,
    output logic [YW-1:0] VGA_Y,
    output logic [2:0]    VGA_COLOR,
    output logic          plot
);

    localparam int unsigned XE = XW + 1;
    localparam int unsigned YE = YW + 1;
    localparam logic [XE-1:0] XRES_E = XE'(XRES);
    localparam logic [YE-1:0] YRES_E = YE'(YRES);

    typedef enum logic [1:0] {IDLE, FILL, FIN} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x0_q, x0_d;
    logic [YW-1:0] y0_q, y0_d;
    logic [2:0]    col_q, col_d;
    logic [XE-1:0] ew_q, ew_d;
    logic [YE-1:0] eh_q, eh_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          plot_q, plot_d;
    logic [XW-1:0] vx_q, vx_d;
    logic [YW-1:0] vy_q, vy_d;
    logic [2:0]    vc_q, vc_d;
`ifdef VGA_RECT_OUTLINE_EN
    logic          outline_q, outline_d;
`endif

    logic [XE-1:0] xroom_c, ew_c;
    logic [YE-1:0] yroom_c, eh_c;
    logic          last_col_c, last_row_c, draw_c;

    // Clipped extents, computed one bit wider so origin+size cannot wrap
    always_comb begin
        xroom_c = XRES_E - {1'b0, x0};
        yroom_c = YRES_E - {1'b0, y0};
        if ({1'b0, x0} >= XRES_E)
            ew_c = '0;
        else if ({1'b0, width} < xroom_c)
            ew_c = {1'b0, width};
        else
            ew_c = xroom_c;
        if ({1'b0, y0} >= YRES_E)
            eh_c = '0;
        else if ({1'b0, height} < yroom_c)
            eh_c = {1'b0, height};
        else
            eh_c = yroom_c;
    end

    assign last_col_c = ({1'b0, cx_q} == (ew_q - XE'(1)));
    assign last_row_c = ({1'b0, cy_q} == (eh_q - YE'(1)));

`ifdef VGA_RECT_OUTLINE_EN
    assign draw_c = !outline_q || (cx_q == '0) || (cy_q == '0) || last_col_c || last_row_c;
`else
    assign draw_c = 1'b1;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        col_d   = col_q;
        ew_d    = ew_q;
        eh_d    = eh_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        plot_d  = 1'b0;
        vx_d    = vx_q;
        vy_d    = vy_q;
        vc_d    = vc_q;
`ifdef VGA_RECT_OUTLINE_EN
        outline_d = outline_q;
`endif
        case (state_q)
            IDLE: begin
                // done_q high means FIN just retired; a start in that cycle is dropped
                if (start && !done_q) begin
                    x0_d  = x0;
                    y0_d  = y0;
                    col_d = color;
                    ew_d  = ew_c;
                    eh_d  = eh_c;
                    cx_d  = '0;
                    cy_d  = '0;
`ifdef VGA_RECT_OUTLINE_EN
                    outline_d = outline;
`endif
                    state_d = ((ew_c == '0) || (eh_c == '0)) ? FIN : FILL;
                end
            end
            FILL: begin
                busy_d = 1'b1;
                plot_d = draw_c;
                if (draw_c) begin
                    vx_d = x0_q + cx_q;
                    vy_d = y0_q + cy_q;
                    vc_d = col_q;
                end
                if (last_col_c && last_row_c) begin
                    state_d = FIN;
                end else if (last_col_c) begin
                    cx_d = '0;
                    cy_d = cy_q + 1'b1;
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            col_q   <= '0;
            ew_q    <= '0;
            eh_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            plot_q  <= 1'b0;
            vx_q    <= '0;
            vy_q    <= '0;
            vc_q    <= '0;
`ifdef VGA_RECT_OUTLINE_EN
            outline_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            col_q   <= col_d;
            ew_q    <= ew_d;
            eh_q    <= eh_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            plot_q  <= plot_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            vc_q    <= vc_d;
`ifdef VGA_RECT_OUTLINE_EN
            outline_q <= outline_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign plot      = plot_q;
    assign VGA_X     = vx_q;
    assign VGA_Y     = vy_q;
    assign VGA_COLOR = vc_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill (160x120 build); outline case runs when VGA_RECT_OUTLINE_EN is defined.
module tb_vga_rect_fill;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] width;
    logic [6:0] height;
    logic [2:0] color;
    logic       outline;
    logic       busy, done, plot;
    logic [7:0] VGA_X;
    logic [6:0] VGA_Y;
    logic [2:0] VGA_COLOR;

    always #5 clk = ~clk;

    vga_rect_fill #(.XW(8), .YW(7), .XRES(160), .YRES(120)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .start    (start),
        .x0       (x0),
        .y0       (y0),
        .width    (width),
        .height   (height),
        .color    (color),
`ifdef VGA_RECT_OUTLINE_EN
        .outline  (outline),
`endif
        .busy     (busy),
        .done     (done),
        .VGA_X    (VGA_X),
        .VGA_Y    (VGA_Y),
        .VGA_COLOR(VGA_COLOR),
        .plot     (plot)
    );

    int n_err = 0;
    int n_chk = 0;
    int qx[$], qy[$], qc[$];
    int nbusy, done_k, first_k, last_k;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input int x, input int y, input int w, input int h, input int c);
        x0     = 8'(x);
        y0     = 7'(y);
        width  = 8'(w);
        height = 7'(h);
        color  = 3'(c);
    endtask

    // Called at a negedge: start is sampled on the following posedge
    task automatic issue(input int x, input int y, input int w, input int h, input int c);
        set_cmd(x, y, w, h, c);
        start = 1'b1;
    endtask

    // k counts negedges after the start edge; the first write is expected at k=1
    task automatic run(input int budget, input bit retrig);
        qx.delete(); qy.delete(); qc.delete();
        nbusy = 0; done_k = -1; first_k = -1; last_k = -1;
        for (int k = 0; k <= budget; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (plot) begin
                qx.push_back(int'(VGA_X));
                qy.push_back(int'(VGA_Y));
                qc.push_back(int'(VGA_COLOR));
                if (first_k < 0) first_k = k;
                last_k = k;
                chk("bounds", {31'd0, (VGA_X < 8'd160) && (VGA_Y < 7'd120)}, 32'd1);
            end
            if (busy) nbusy++;
            if (retrig && k == 2) issue(60, 60, 1, 1, 6);
            if (done) begin
                done_k = k;
                if (retrig) issue(50, 50, 1, 1, 1);
                break;
            end
        end
        chk("done_seen", {31'd0, done_k >= 0}, 32'd1);
    endtask

    task automatic chk_px(input int i, input int ex, input int ey, input int ec);
        if (i < qx.size()) begin
            chk($sformatf("px%0d_x", i), qx[i], ex);
            chk($sformatf("px%0d_y", i), qy[i], ey);
            chk($sformatf("px%0d_c", i), qc[i], ec);
        end else begin
            chk($sformatf("px%0d_present", i), qx.size(), i + 1);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; outline = 1'b0;
        set_cmd(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_plot", plot, 0);
        chk("rst_x", VGA_X, 0);
        chk("rst_y", VGA_Y, 0);
        chk("rst_c", VGA_COLOR, 0);
        @(negedge clk);

        // Basic 3x2 fill
        issue(10, 5, 3, 2, 4);
        run(40, 0);
        chk("t1_npix", qx.size(), 6);
        chk_px(0, 10, 5, 4); chk_px(1, 11, 5, 4); chk_px(2, 12, 5, 4);
        chk_px(3, 10, 6, 4); chk_px(4, 11, 6, 4); chk_px(5, 12, 6, 4);
        chk("t1_first_k", first_k, 1);
        chk("t1_last_k", last_k, 6);
        chk("t1_busy_cycles", nbusy, 6);
        chk("t1_done_k", done_k, 7);
        chk("t1_hold_x", VGA_X, 12);
        chk("t1_hold_y", VGA_Y, 6);
        chk("t1_hold_c", VGA_COLOR, 4);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);

        // Right/bottom clipping
        issue(158, 119, 5, 4, 2);
        run(40, 0);
        chk("t2_npix", qx.size(), 2);
        chk_px(0, 158, 119, 2); chk_px(1, 159, 119, 2);
        chk("t2_done_k", done_k, 3);
        @(negedge clk);

        // Empty: zero width, then origin off-screen
        issue(20, 20, 0, 5, 1);
        run(20, 0);
        chk("t3a_npix", qx.size(), 0);
        chk("t3a_busy", nbusy, 0);
        chk("t3a_done_k", done_k, 1);
        @(negedge clk);
        issue(200, 20, 3, 3, 1);
        run(20, 0);
        chk("t3b_npix", qx.size(), 0);
        chk("t3b_done_k", done_k, 1);
        @(negedge clk);

        // Retrigger mid-FILL and on the done cycle, then a start one cycle after done
        issue(20, 30, 2, 2, 2);
        run(40, 1);
        chk("t4_npix", qx.size(), 4);
        chk_px(0, 20, 30, 2); chk_px(1, 21, 30, 2);
        chk_px(2, 20, 31, 2); chk_px(3, 21, 31, 2);
        chk("t4_done_k", done_k, 5);
        @(negedge clk);
        chk("t4_after_busy", busy, 0);
        chk("t4_after_plot", plot, 0);
        issue(7, 8, 1, 1, 5);
        run(20, 0);
        chk("t4b_npix", qx.size(), 1);
        chk_px(0, 7, 8, 5);
        chk("t4b_done_k", done_k, 2);
        @(negedge clk);

        // Reset during the third pixel of a 4x4 fill
        issue(30, 40, 4, 4, 7);
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("t5_px3_plot", plot, 1);
        chk("t5_px3_x", VGA_X, 32);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_rst_plot", plot, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        begin
            int nd = 0;
            int np = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done) nd++;
                if (plot) np++;
            end
            chk("t5_no_done", nd, 0);
            chk("t5_no_plot", np, 0);
        end
        issue(0, 0, 1, 1, 3);
        run(20, 0);
        chk("t5b_npix", qx.size(), 1);
        chk_px(0, 0, 0, 3);
        chk("t5b_done_k", done_k, 2);
        @(negedge clk);

`ifdef VGA_RECT_OUTLINE_EN
        // Border-only 4x3 at origin
        outline = 1'b1;
        issue(0, 0, 4, 3, 6);
        run(40, 0);
        outline = 1'b0;
        chk("t6_busy_cycles", nbusy, 12);
        chk("t6_npix", qx.size(), 10);
        chk("t6_done_k", done_k, 13);
        begin
            int inner = 0;
            foreach (qx[i]) if (qy[i] == 1 && (qx[i] == 1 || qx[i] == 2)) inner++;
            chk("t6_interior", inner, 0);
        end
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
